tsv_tx_scheduler: RTL and testbench

TSV_TX_SCHEDULER -- requirements
Module: tsv_tx_scheduler

---
 rtl/tsv_tx_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_tsv_tx_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tsv_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tsv_tx_scheduler
// Description : Round-robin burst scheduler that multiplexes NREQ requesters
//               onto a shared DW-lane TSV bundle.
//               - Arbitration in IDLE picks the first requesting index at or
//                 above the round-robin pointer, with wrap-around.
//               - A grant lasts until a word marked last is accepted, until
//                 MAX_BURST beats have been accepted, or until the owner stops
//                 requesting.
//               - Each burst is followed by TURN_CYC idle cycles so that two
//                 owners never drive back to back.
//               - tsv_data holds its previous value on idle cycles so that
//                 the TSV lanes do not toggle needlessly.
// Ports       : clk, rst (synchronous, active-high)
//               req[NREQ], req_data[NREQ*DW], req_last[NREQ]  requester side
//               gnt[NREQ] (registered), ack[NREQ] (gnt & req, comb)
//               tsv_data[DW], tsv_valid, tsv_owner      registered TSV side
//               tsv_parity (only with TSV_SCHED_PARITY_EN): even parity
//               of the word loaded into tsv_data
// Config      : define TSV_SCHED_PARITY_EN to add the tsv_parity output.
// Revision    : 1.0 - initial release
// ============================================================================
module tsv_tx_scheduler #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4,
    parameter int TURN_CYC  = 1,
    localparam int c_PW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      tsv_data,
    output logic               tsv_valid,
    output logic [c_PW-1:0]    tsv_owner
`ifdef TSV_SCHED_PARITY_EN
    ,
    output logic               tsv_parity
`endif
);

    // A turnaround of zero cycles is treated as one so TURN always lasts.
    localparam int c_TC = (TURN_CYC < 1) ? 1 : TURN_CYC;
    localparam int c_TW = (c_TC > 1) ? $clog2(c_TC) : 1;
    localparam int c_CW = $clog2(MAX_BURST + 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_BURST = 2'd1;
    localparam logic [1:0] c_S_TURN  = 2'd2;

    logic [1:0]      r_state,      w_state;
    logic [c_PW-1:0] r_rr_ptr,     w_rr_ptr;
    logic [c_PW-1:0] r_owner,      w_owner;
    logic [c_CW-1:0] r_beat_cnt,   w_beat_cnt;
    logic [c_TW-1:0] r_turn_cnt,   w_turn_cnt;
    logic [NREQ-1:0] r_gnt,        w_gnt;
    logic [DW-1:0]   r_tsv_data,   w_tsv_data;
    logic            r_tsv_valid,  w_tsv_valid;
    logic [c_PW-1:0] r_tsv_owner,  w_tsv_owner;
`ifdef TSV_SCHED_PARITY_EN
    logic            r_tsv_parity, w_tsv_parity;
`endif

    // Round-robin search result
    logic            w_any;
    logic [c_PW-1:0] w_win;
    int              v_idx;

    // Granted requester's inputs
    logic            w_sel_req;
    logic            w_sel_last;
    logic [DW-1:0]   w_sel_data;
    logic            w_end;

    // ------------------------------------------------------------------
    // Round-robin winner: first set req bit at or above r_rr_ptr, wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        w_any = 1'b0;
        w_win = r_rr_ptr;
        v_idx = 0;
        for (int i = 0; i < NREQ; i++) begin
            v_idx = int'(r_rr_ptr) + i;
            if (v_idx >= NREQ) begin
                v_idx = v_idx - NREQ;
            end
            if (!w_any && req[v_idx]) begin
                w_any = 1'b1;
                w_win = c_PW'(v_idx);
            end
        end
    end

    assign w_sel_req  = req[r_owner];
    assign w_sel_last = req_last[r_owner];
    assign w_sel_data = req_data[int'(r_owner)*DW +: DW];

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state      = r_state;
        w_rr_ptr     = r_rr_ptr;
        w_owner      = r_owner;
        w_beat_cnt   = r_beat_cnt;
        w_turn_cnt   = r_turn_cnt;
        w_gnt        = r_gnt;
        w_tsv_data   = r_tsv_data;   // held on idle cycles
        w_tsv_valid  = 1'b0;
        w_tsv_owner  = r_tsv_owner;
`ifdef TSV_SCHED_PARITY_EN
        w_tsv_parity = r_tsv_parity;
`endif
        w_end        = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                w_gnt = '0;
                if (w_any) begin
                    w_state        = c_S_BURST;
                    w_owner        = w_win;
                    w_gnt[w_win]   = 1'b1;
                    w_beat_cnt     = '0;
                end
            end

            c_S_BURST: begin
                if (w_sel_req) begin
                    w_tsv_data   = w_sel_data;
                    w_tsv_valid  = 1'b1;
                    w_tsv_owner  = r_owner;
`ifdef TSV_SCHED_PARITY_EN
                    w_tsv_parity = ^w_sel_data;
`endif
                    w_beat_cnt   = r_beat_cnt + c_CW'(1);
                    // Counter reaches MAX_BURST on the final beat and stops.
                    w_end = w_sel_last || (r_beat_cnt == c_CW'(MAX_BURST - 1));
                end else begin
                    // Owner ran dry: release the bus instead of waiting.
                    w_end = 1'b1;
                end
                if (w_end) begin
                    w_state    = c_S_TURN;
                    w_gnt      = '0;
                    w_turn_cnt = '0;
                    w_rr_ptr   = (r_owner == c_PW'(NREQ - 1)) ? '0
                                                              : r_owner + c_PW'(1);
                end
            end

            c_S_TURN: begin
                w_gnt = '0;
                if (r_turn_cnt == c_TW'(c_TC - 1)) begin
                    w_state = c_S_IDLE;
                end else begin
                    w_turn_cnt = r_turn_cnt + c_TW'(1);
                end
            end

            default: begin
                w_state = c_S_IDLE;
                w_gnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_S_IDLE;
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_beat_cnt   <= '0;
            r_turn_cnt   <= '0;
            r_gnt        <= '0;
            r_tsv_data   <= '0;
            r_tsv_valid  <= 1'b0;
            r_tsv_owner  <= '0;
`ifdef TSV_SCHED_PARITY_EN
            r_tsv_parity <= 1'b0;
`endif
        end else begin
            r_state      <= w_state;
            r_rr_ptr     <= w_rr_ptr;
            r_owner      <= w_owner;
            r_beat_cnt   <= w_beat_cnt;
            r_turn_cnt   <= w_turn_cnt;
            r_gnt        <= w_gnt;
            r_tsv_data   <= w_tsv_data;
            r_tsv_valid  <= w_tsv_valid;
            r_tsv_owner  <= w_tsv_owner;
`ifdef TSV_SCHED_PARITY_EN
            r_tsv_parity <= w_tsv_parity;
`endif
        end
    end

    // ack is gated by rst so that no word is consumed while the block is
    // being reset, even though gnt only clears at the reset edge.
    assign ack       = rst ? '0 : (r_gnt & req);
    assign gnt       = r_gnt;
    assign tsv_data  = r_tsv_data;
    assign tsv_valid = r_tsv_valid;
    assign tsv_owner = r_tsv_owner;
`ifdef TSV_SCHED_PARITY_EN
    assign tsv_parity = r_tsv_parity;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tsv_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tsv_tx_scheduler
// Description : Scoreboard bench for tsv_tx_scheduler. A behavioural model
//               (owner index, remaining turnaround, beat count, pointer)
//               predicts gnt/ack each cycle and pushes every expected TSV
//               beat into a queue; an independent monitor pops the queue
//               whenever the DUT shows tsv_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tsv_tx_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MB   = 4;
    localparam int TC   = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic [DW-1:0]     tsv_data;
    logic              tsv_valid;
    logic [1:0]        tsv_owner;
`ifdef TSV_SCHED_PARITY_EN
    logic              tsv_parity;
`endif

    tsv_tx_scheduler #(
        .NREQ      (NREQ),
        .DW        (DW),
        .MAX_BURST (MB),
        .TURN_CYC  (TC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .req_last  (req_last),
        .gnt       (gnt),
        .ack       (ack),
        .tsv_data  (tsv_data),
        .tsv_valid (tsv_valid),
        .tsv_owner (tsv_owner)
`ifdef TSV_SCHED_PARITY_EN
        ,
        .tsv_parity(tsv_parity)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         owner;
        int         cyc;
    } beat_t;

    beat_t q[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model state: m_owner < 0 means nobody holds the bus.
    int m_owner = -1;
    int m_turn  = 0;
    int m_beats = 0;
    int m_ptr   = 0;

    logic [7:0] last_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock of the model, evaluated with this cycle's inputs.
    task automatic model_step(output int acc);
        logic [3:0] eg;
        logic [3:0] ea;
        logic       fin;
        beat_t      b;
        acc = -1;
        eg  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        ea  = rst ? 4'b0 : (eg & req);
        check("gnt", 32'(gnt), 32'(eg));
        check("ack", 32'(ack), 32'(ea));
        if (rst) begin
            m_owner = -1;
            m_turn  = 0;
            m_beats = 0;
            m_ptr   = 0;
        end else if (m_turn > 0) begin
            m_turn--;
        end else if (m_owner < 0) begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_owner < 0 && req[(m_ptr + i) % NREQ]) begin
                    m_owner = (m_ptr + i) % NREQ;
                    m_beats = 0;
                end
            end
        end else begin
            fin = 1'b0;
            if (req[m_owner]) begin
                b.data  = req_data[m_owner*DW +: DW];
                b.owner = m_owner;
                b.cyc   = cyc;
                q.push_back(b);
                acc = m_owner;
                m_beats++;
                if (req_last[m_owner] || m_beats == MB) fin = 1'b1;
            end else begin
                fin = 1'b1;
            end
            if (fin) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
                m_turn  = TC;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic [3:0] rq,
                         input logic [3:0] lst, input logic [31:0] dat,
                         output int acc);
        @(negedge clk);
        rst      = r;
        req      = rq;
        req_last = lst;
        req_data = dat;
        #1;
        cyc++;
        model_step(acc);
    endtask

    // Monitor: runs just after each rising edge.
    initial begin
        beat_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                check("rst_valid", 32'(tsv_valid), 32'd0);
                check("rst_data",  32'(tsv_data),  32'd0);
                check("rst_owner", 32'(tsv_owner), 32'd0);
                last_data = 8'h00;
            end else if (tsv_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 32'(tsv_data), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    check("beat_latency", 32'(cyc), 32'(e.cyc));
                    check("beat_data",  32'(tsv_data),  32'(e.data));
                    check("beat_owner", 32'(tsv_owner), 32'(e.owner));
`ifdef TSV_SCHED_PARITY_EN
                    check("beat_parity", 32'(tsv_parity), 32'(^e.data));
`endif
                    last_data = e.data;
                end
            end else begin
                check("hold_data", 32'(tsv_data), 32'(last_data));
                if (q.size() > 0 && q[0].cyc <= cyc) begin
                    e = q.pop_front();
                    check("missing_beat", 32'(tsv_valid), 32'd1);
                end
            end
        end
    end

    initial begin
        int         acc;
        int         k;
        logic       done;
        logic [7:0] w;
        logic [3:0] rq;
        logic [3:0] lst;
        rst      = 1'b1;
        req      = 4'hF;
        req_last = 4'h0;
        req_data = '0;

        // Reset hold with every requester asking.
        repeat (3) cycle(1'b1, 4'hF, 4'h0, 32'h0, acc);

        // Single 3-beat burst from requester 2: 11, 22, 33, last on third.
        k = 0;
        for (int i = 0; i < 10; i++) begin
            w = {4'(k + 1), 4'(k + 1)};
            cycle(1'b0, (k < 3) ? 4'b0100 : 4'b0000, (k == 2) ? 4'b0100 : 4'b0000,
                  {8'h00, w, 16'h0000}, acc);
            if (acc == 2) k++;
        end

        // Parity words 07 and 03 from requester 3 as a 2-beat burst.
        k = 0;
        for (int i = 0; i < 6; i++) begin
            w = (k == 0) ? 8'h07 : 8'h03;
            cycle(1'b0, (k < 2) ? 4'b1000 : 4'b0000, (k == 1) ? 4'b1000 : 4'b0000,
                  {w, 24'h0}, acc);
            if (acc == 3) k++;
        end

        // Burst cap: requester 0 never marks last.
        repeat (16) cycle(1'b0, 4'b0001, 4'b0000, $urandom, acc);

        // Round robin with single-beat bursts from everybody.
        repeat (24) cycle(1'b0, 4'hF, 4'hF, $urandom, acc);

        // Requester 1 stalls after two beats.
        k = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, (k < 2) ? 4'b0010 : 4'b0000, 4'b0000, $urandom, acc);
            if (acc == 1) k++;
        end

        // Reset pulse while beat 2 of requester 1 is offered.
        k = 0;
        done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle((k == 1 && !done), 4'b0010, 4'b0000, $urandom, acc);
            if (rst) done = 1'b1;
            if (acc == 1) k++;
        end
        // Right after reset all ask: pointer back at 0.
        repeat (12) cycle(1'b0, 4'hF, 4'h0, $urandom, acc);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                rq[j]  = ($urandom_range(3) != 0);
                lst[j] = ($urandom_range(9) < 3);
            end
            cycle(($urandom_range(99) == 0), rq, lst, $urandom, acc);
        end

        // Drain.
        repeat (4) cycle(1'b0, 4'h0, 4'h0, 32'h0, acc);
        @(posedge clk);
        #2;
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
